// File: rtl/mul_issue_ctrl_pkg.sv
// Shared encodings for the RV64M multiply issue controller:
// op codes, multiplier signedness, controller states, cache entry.
package mul_issue_ctrl_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        RESP
    } state_e;

    typedef struct packed {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [1:0]  sgn;
        logic [63:0] hi;
        logic [63:0] lo;
    } cache_t;

    // Reserved encodings 5-7 execute as plain MUL.
    function automatic logic [2:0] op_norm(input logic [2:0] op);
        return (op > OP_MULW) ? OP_MUL : op;
    endfunction

    function automatic logic [1:0] op_sgn(input logic [2:0] op);
        case (op)
            OP_MULHSU: return SGN_SU;
            OP_MULHU:  return SGN_UU;
            default:   return SGN_SS;
        endcase
    endfunction

    function automatic logic op_is_hi(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/mul_result_fmt.sv
// Picks the product half an op returns and sign-extends MULW.
// Shared by the multiplier return path and the cache hit path.
module mul_result_fmt
    import mul_issue_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [63:0] hi_i,
    input  logic [63:0] lo_i,
    output logic [63:0] res_o
);

    logic [2:0] op;

    assign op = op_norm(op_i);

    always_comb begin
        res_o = lo_i;
        unique case (1'b1)
            op_is_hi(op):     res_o = hi_i;
            (op == OP_MULW): res_o = {{32{lo_i[31]}}, lo_i[31:0]};
            default:          res_o = lo_i;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EXU-side issue controller in front of the radix-4 Booth multiplier,
// with a one-entry product cache for MULH-then-MUL pairs.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        m_valid,
    output logic        m_flush,
    output logic        m_mulw,
    output logic [1:0]  m_signed,
    output logic [63:0] m_multiplicand,
    output logic [63:0] m_multiplier,
    input  logic        m_ready,
    input  logic        m_out_valid,
    input  logic [63:0] m_result_h,
    input  logic [63:0] m_result_l
);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [63:0] src1_q;
    logic [63:0] src2_q;
    logic [4:0]  rd_q;
    logic [1:0]  sgn_q;
    logic        mulw_q;
    logic [63:0] data_q;
    logic        out_valid_q;
    logic        cvld_q;
    cache_t      cache_q;

    logic [2:0]  in_op_n;
    logic [1:0]  in_sgn;
    logic        accept;
    logic        key_eq;
    logic        cls_ok;
    logic        hit;
    logic [63:0] fmt_mul;
    logic [63:0] fmt_hit;

    assign in_op_n = op_norm(in_op);
    assign in_sgn  = op_sgn(in_op_n);
    assign in_ready = (state_q == IDLE) && !flush;
    assign accept  = in_valid && in_ready;

    // The low half is signedness-independent, so MUL reuses any entry.
    assign key_eq = (in_src1 == cache_q.src1) && (in_src2 == cache_q.src2);
    assign cls_ok = (in_op_n == OP_MUL) || (in_sgn == cache_q.sgn);
    assign hit    = CACHE_EN && cvld_q && key_eq && cls_ok
                    && (in_op_n != OP_MULW);

    mul_result_fmt u_fmt_mul (
        .op_i  (op_q),
        .hi_i  (m_result_h),
        .lo_i  (m_result_l),
        .res_o (fmt_mul)
    );

    mul_result_fmt u_fmt_hit (
        .op_i  (in_op_n),
        .hi_i  (cache_q.hi),
        .lo_i  (cache_q.lo),
        .res_o (fmt_hit)
    );

    // The Booth core only advances while MulValid is high, so it
    // stays up for all of REQ and until the core drains after a kill.
    always_comb begin
        m_valid = 1'b0;
        m_flush = 1'b0;
        unique case (state_q)
            REQ: begin
                m_valid = 1'b1;
                m_flush = flush;
            end
            DRAIN: begin
                m_valid = !m_ready;
                m_flush = !m_ready;
            end
            default: begin
                m_valid = 1'b0;
                m_flush = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            src1_q      <= '0;
            src2_q      <= '0;
            rd_q        <= '0;
            sgn_q       <= SGN_SS;
            mulw_q      <= 1'b0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            cvld_q      <= 1'b0;
            cache_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q   <= in_op_n;
                        src1_q <= in_src1;
                        src2_q <= in_src2;
                        rd_q   <= in_rd;
                        sgn_q  <= in_sgn;
                        mulw_q <= (in_op_n == OP_MULW);
                        if (hit) begin
                            data_q      <= fmt_hit;
                            out_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (m_out_valid) begin
                        data_q      <= fmt_mul;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                        if (!mulw_q) begin
                            cvld_q  <= CACHE_EN;
                            cache_q <= '{
                                src1: src1_q,
                                src2: src2_q,
                                sgn:  sgn_q,
                                hi:   m_result_h,
                                lo:   m_result_l
                            };
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = data_q;
    assign out_rd         = rd_q;
    assign m_mulw         = mulw_q;
    assign m_signed       = sgn_q;
    assign m_multiplicand = src1_q;
    assign m_multiplier   = src2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a Booth-multiplier stand-in plus an
// arithmetic product/cache reference, directed and random ops.
module tb_mul_issue_ctrl;

    localparam logic [2:0] T_MUL    = 3'd0;
    localparam logic [2:0] T_MULH   = 3'd1;
    localparam logic [2:0] T_MULHSU = 3'd2;
    localparam logic [2:0] T_MULHU  = 3'd3;
    localparam logic [2:0] T_MULW   = 3'd4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        m_valid;
    logic        m_flush;
    logic        m_mulw;
    logic [1:0]  m_signed;
    logic [63:0] m_multiplicand;
    logic [63:0] m_multiplier;
    logic        m_ready;
    logic        m_out_valid;
    logic [63:0] m_result_h;
    logic [63:0] m_result_l;

    int n_cmp = 0;
    int n_err = 0;

    mul_issue_ctrl #(.CACHE_EN(1'b1)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_src1        (in_src1),
        .in_src2        (in_src2),
        .in_rd          (in_rd),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd         (out_rd),
        .m_valid        (m_valid),
        .m_flush        (m_flush),
        .m_mulw         (m_mulw),
        .m_signed       (m_signed),
        .m_multiplicand (m_multiplicand),
        .m_multiplier   (m_multiplier),
        .m_ready        (m_ready),
        .m_out_valid    (m_out_valid),
        .m_result_h     (m_result_h),
        .m_result_l     (m_result_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: takes an op when ready, counts mlat cycles
    // only while MulValid stays high, answers, and drains mdrain cycles
    // after a kill.
    int          mlat = 3;
    int          mdrain = 2;
    int          n_acc = 0;
    int          hold_err = 0;
    logic        mb_busy;
    logic        mb_flushing;
    int          mb_cnt;
    logic [63:0] mb_a;
    logic [63:0] mb_b;
    logic [1:0]  mb_sgn;

    function automatic logic [127:0] prod(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic sa, input logic sb);
        logic [127:0] xa;
        logic [127:0] xb;
        xa = sa ? {{64{a[63]}}, a} : {64'd0, a};
        xb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return xa * xb;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_ready     <= 1'b1;
            m_out_valid <= 1'b0;
            m_result_h  <= '0;
            m_result_l  <= '0;
            mb_busy     <= 1'b0;
            mb_flushing <= 1'b0;
            mb_cnt      <= 0;
        end else begin
            m_out_valid <= 1'b0;
            if ((mb_busy && (!m_valid || m_multiplicand !== mb_a
                 || m_multiplier !== mb_b || m_signed !== mb_sgn))
                || (m_out_valid && !m_valid))
                hold_err <= hold_err + 1;
            if (mb_flushing) begin
                if (mb_cnt <= 1) begin
                    mb_flushing <= 1'b0;
                    m_ready     <= 1'b1;
                end else begin
                    mb_cnt <= mb_cnt - 1;
                end
            end else if (m_flush) begin
                mb_busy     <= 1'b0;
                mb_flushing <= 1'b1;
                m_ready     <= 1'b0;
                mb_cnt      <= mdrain;
            end else if (mb_busy) begin
                if (m_valid) begin
                    if (mb_cnt <= 1) begin
                        {m_result_h, m_result_l} <= prod(mb_a, mb_b,
                                                         mb_sgn[1], mb_sgn[0]);
                        m_out_valid <= 1'b1;
                        mb_busy     <= 1'b0;
                    end else begin
                        mb_cnt <= mb_cnt - 1;
                    end
                end
            end else if (m_out_valid) begin
                m_ready <= 1'b1;
            end else if (m_ready && m_valid) begin
                mb_a    <= m_multiplicand;
                mb_b    <= m_multiplier;
                mb_sgn  <= m_signed;
                mb_busy <= 1'b1;
                mb_cnt  <= mlat;
                m_ready <= 1'b0;
                n_acc   <= n_acc + 1;
            end
        end
    end

    // Reference: architectural result and the last product computed.
    logic        rc_valid = 1'b0;
    logic [63:0] rc_a;
    logic [63:0] rc_b;
    int          rc_cls;

    function automatic logic [2:0] nrm(input logic [2:0] op);
        return (op > 3'd4) ? T_MUL : op;
    endfunction

    function automatic int ref_cls(input logic [2:0] op);
        if (nrm(op) == T_MULHSU) return 1;
        if (nrm(op) == T_MULHU) return 2;
        return 0;
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        logic [2:0] o;
        o = nrm(op);
        p = prod(a, b, o != T_MULHU, o == T_MUL || o == T_MULH
                                     || o == T_MULW);
        if (o == T_MULH || o == T_MULHSU || o == T_MULHU) return p[127:64];
        if (o == T_MULW) return {{32{p[31]}}, p[31:0]};
        return p[63:0];
    endfunction

    function automatic logic ref_hit(input logic [2:0] op,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        if (!rc_valid || a !== rc_a || b !== rc_b || nrm(op) == T_MULW)
            return 1'b0;
        return (nrm(op) == T_MUL) || (ref_cls(op) == rc_cls);
    endfunction

    task automatic ref_commit(input logic [2:0] op, input logic [63:0] a,
                              input logic [63:0] b);
        if (nrm(op) != T_MULW) begin
            rc_valid = 1'b1;
            rc_a = a;
            rc_b = b;
            rc_cls = ref_cls(op);
        end
    endtask

    // Issue one op from IDLE and wait (bounded) for out_valid.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          output int lat, output int acc,
                          output logic [1:0] sgn, output logic mw,
                          output logic mv_ok);
        int acc0;
        acc0 = n_acc;
        in_valid = 1'b1;
        in_op = op;
        in_src1 = a;
        in_src2 = b;
        in_rd = rd;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        sgn = m_signed;
        mw = m_mulw;
        mv_ok = 1'b1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (!m_valid) mv_ok = 1'b0;
            @(negedge clock);
            lat++;
        end
        if (!out_valid) lat = -1;
        acc = n_acc - acc0;
    endtask

    task automatic release_out(input int bp);
        repeat (bp) @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (m_valid !== 1'b0 || m_flush !== 1'b0) begin n_err++;
            $display("FAIL reset_m_valid_flush got %0b%0b want 00", m_valid, m_flush); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_data !== 64'd0 || m_multiplicand !== 64'd0) begin n_err++;
            $display("FAIL reset_regs got %h %h want 0", out_data, m_multiplicand); end
        reset = 1'b0;
        rc_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mulhu();
        int lat, acc;
        logic [1:0] sg;
        logic mw, mv;
        logic [63:0] exp;
        mlat = 4;
        exp = ref_result(T_MULHU, '1, 64'd2);
        run_op(T_MULHU, '1, 64'd2, 5'd7, lat, acc, sg, mw, mv);
        n_cmp++; if (lat < 2) begin n_err++;
            $display("FAIL mulhu_latency got %0d want >=2", lat); end
        n_cmp++; if (out_data !== exp) begin n_err++;
            $display("FAIL mulhu_data got %h want %h", out_data, exp); end
        n_cmp++; if (out_rd !== 5'd7) begin n_err++;
            $display("FAIL mulhu_rd got %0d want 7", out_rd); end
        n_cmp++; if (sg !== 2'b00 || mw !== 1'b0) begin n_err++;
            $display("FAIL mulhu_signed got %b/%b want 00/0", sg, mw); end
        n_cmp++; if (mv !== 1'b1 || acc !== 1) begin n_err++;
            $display("FAIL mulhu_req got mv=%0b acc=%0d want 1/1", mv, acc); end
        n_cmp++; if (hold_err !== 0) begin n_err++;
            $display("FAIL mulhu_hold got %0d want 0", hold_err); end
        release_out(0);
        ref_commit(T_MULHU, '1, 64'd2);
    endtask

    task automatic test_cache_pair();
        int lat, acc;
        logic [1:0] sg;
        logic mw, mv;
        logic [63:0] exp;
        logic eh;
        mlat = 3;
        run_op(T_MULH, '1, '1, 5'd3, lat, acc, sg, mw, mv);
        exp = ref_result(T_MULH, '1, '1);
        n_cmp++; if (out_data !== exp || acc !== 1) begin n_err++;
            $display("FAIL pair_mulh got %h acc=%0d want %h acc=1", out_data, acc, exp); end
        n_cmp++; if (sg !== 2'b11) begin n_err++;
            $display("FAIL pair_mulh_signed got %b want 11", sg); end
        release_out(1);
        ref_commit(T_MULH, '1, '1);
        eh = ref_hit(T_MUL, '1, '1);
        run_op(T_MUL, '1, '1, 5'd4, lat, acc, sg, mw, mv);
        exp = ref_result(T_MUL, '1, '1);
        n_cmp++; if (out_data !== exp || out_rd !== 5'd4) begin n_err++;
            $display("FAIL pair_mul_data got %h/%0d want %h/4", out_data, out_rd, exp); end
        n_cmp++; if (eh !== 1'b1 || lat !== 1 || acc !== 0) begin n_err++;
            $display("FAIL pair_mul_hit got lat=%0d acc=%0d want 1/0", lat, acc); end
        release_out(0);
        // Different signedness class on the same operands must re-run.
        run_op(T_MULHU, '1, '1, 5'd5, lat, acc, sg, mw, mv);
        exp = ref_result(T_MULHU, '1, '1);
        n_cmp++; if (out_data !== exp || acc !== 1) begin n_err++;
            $display("FAIL pair_mulhu_miss got %h acc=%0d want %h acc=1", out_data, acc, exp); end
        release_out(0);
        ref_commit(T_MULHU, '1, '1);
    endtask

    task automatic test_mulw();
        int lat, acc;
        logic [1:0] sg;
        logic mw, mv;
        logic [63:0] exp;
        exp = ref_result(T_MULW, 64'h7FFF_FFFF, 64'd2);
        for (int k = 0; k < 2; k++) begin
            mlat = 2 + k;
            run_op(T_MULW, 64'h7FFF_FFFF, 64'd2, 5'd10, lat, acc, sg, mw, mv);
            n_cmp++; if (out_data !== exp) begin n_err++;
                $display("FAIL mulw_data_%0d got %h want %h", k, out_data, exp); end
            n_cmp++; if (mw !== 1'b1 || sg !== 2'b11) begin n_err++;
                $display("FAIL mulw_ctrl_%0d got %b/%b want 1/11", k, mw, sg); end
            n_cmp++; if (acc !== 1 || mv !== 1'b1) begin n_err++;
                $display("FAIL mulw_rerun_%0d got acc=%0d mv=%0b want 1/1", k, acc, mv); end
            release_out(k);
        end
    endtask

    task automatic test_flush();
        int n, lat, acc;
        logic seen_ov;
        logic [1:0] sg;
        logic mw, mv;
        logic eh;
        logic [63:0] exp;
        mlat = 30;
        mdrain = 3;
        in_valid = 1'b1;
        in_op = T_MULH;
        in_src1 = 64'h1234;
        in_src2 = 64'h5678;
        in_rd = 5'd9;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        flush = 1'b1;
        #1;
        n_cmp++; if (m_flush !== 1'b1 || m_valid !== 1'b1) begin n_err++;
            $display("FAIL flush_req got flush=%0b valid=%0b want 1/1", m_flush, m_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        @(negedge clock);
        flush = 1'b0;
        n_cmp++; if (m_flush !== 1'b1 || m_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_drain got %0b%0b%0b want 110", m_flush, m_valid, in_ready); end
        n = 0;
        seen_ov = 1'b0;
        while (!in_ready && n < 50) begin
            if (out_valid) seen_ov = 1'b1;
            @(negedge clock);
            n++;
        end
        n_cmp++; if (in_ready !== 1'b1 || m_flush !== 1'b0) begin n_err++;
            $display("FAIL flush_exit got ready=%0b mflush=%0b want 1/0", in_ready, m_flush); end
        n_cmp++; if (seen_ov !== 1'b0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL flush_no_result got %0b want 0", seen_ov); end
        mlat = 3;
        eh = ref_hit(T_MUL, '1, '1);
        exp = ref_result(T_MUL, '1, '1);
        run_op(T_MUL, '1, '1, 5'd1, lat, acc, sg, mw, mv);
        n_cmp++; if (eh !== 1'b1 || acc !== 0 || lat !== 1 || out_data !== exp) begin n_err++;
            $display("FAIL flush_cache_kept got %h lat=%0d acc=%0d want %h 1/0", out_data, lat, acc, exp); end
        release_out(0);
        run_op(T_MUL, 64'd3, 64'd5, 5'd2, lat, acc, sg, mw, mv);
        n_cmp++; if (out_data !== 64'd15 || acc !== 1) begin n_err++;
            $display("FAIL flush_next_mul got %0d acc=%0d want 15 acc=1", out_data, acc); end
        release_out(0);
        ref_commit(T_MUL, 64'd3, 64'd5);
    endtask

    task automatic test_backpressure();
        int lat, acc;
        logic [1:0] sg;
        logic mw, mv;
        logic [63:0] a, b, exp;
        logic eh;
        mlat = 2;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        eh = ref_hit(T_MUL, a, b);
        exp = ref_result(T_MUL, a, b);
        run_op(T_MUL, a, b, 5'd17, lat, acc, sg, mw, mv);
        n_cmp++; if (eh !== 1'b0 || acc !== 1 || lat < 2) begin n_err++;
            $display("FAIL bp_issue got lat=%0d acc=%0d want miss", lat, acc); end
        in_valid = 1'b1;
        in_op = T_MULHU;
        in_src1 = 64'd11;
        in_src2 = 64'd13;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_hold_%0d got ov=%0b ir=%0b want 1/0", i, out_valid, in_ready); end
            n_cmp++; if (out_data !== exp || out_rd !== 5'd17) begin n_err++;
                $display("FAIL bp_data_%0d got %h/%0d want %h/17", i, out_data, out_rd, exp); end
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_release got ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
        in_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (in_ready !== 1'b1 || m_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_no_reaccept got ir=%0b mv=%0b want 1/0", in_ready, m_valid); end
        ref_commit(T_MUL, a, b);
    endtask

    task automatic test_reset_mid_req();
        int lat, acc;
        logic [1:0] sg;
        logic mw, mv;
        logic [63:0] a, b, exp;
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h0000_0000_1234_5678;
        exp = ref_result(T_MULH, a, b);
        mlat = 3;
        run_op(T_MULH, a, b, 5'd20, lat, acc, sg, mw, mv);
        n_cmp++; if (out_data !== exp) begin n_err++;
            $display("FAIL rst_prime got %h want %h", out_data, exp); end
        release_out(0);
        ref_commit(T_MULH, a, b);
        mlat = 40;
        in_valid = 1'b1;
        in_op = T_MUL;
        in_src1 = 64'd5;
        in_src2 = 64'd7;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0 || m_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_mid got ov=%0b mv=%0b ir=%0b want 0/0/1", out_valid, m_valid, in_ready); end
        reset = 1'b0;
        rc_valid = 1'b0;
        @(negedge clock);
        mlat = 3;
        run_op(T_MULH, a, b, 5'd21, lat, acc, sg, mw, mv);
        n_cmp++; if (acc !== 1 || lat < 2 || out_data !== exp) begin n_err++;
            $display("FAIL rst_cache_cleared got %h lat=%0d acc=%0d want %h miss", out_data, lat, acc, exp); end
        release_out(0);
        ref_commit(T_MULH, a, b);
    endtask

    task automatic test_random();
        logic [63:0] pool [4];
        logic [63:0] a, b, exp;
        logic [2:0] op;
        logic [4:0] rd;
        logic eh, mw, mv;
        logic [1:0] sg;
        int lat, acc, ia, ib;
        pool[0] = '1;
        pool[1] = 64'd3;
        pool[2] = 64'h8000_0000_0000_0000;
        pool[3] = {$urandom, $urandom};
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            ia = $urandom_range(0, 4);
            ib = $urandom_range(0, 4);
            a = (ia == 4) ? {$urandom, $urandom} : pool[ia[1:0]];
            b = (ib == 4) ? {$urandom, $urandom} : pool[ib[1:0]];
            rd = 5'($urandom);
            mlat = $urandom_range(1, 6);
            eh = ref_hit(op, a, b);
            exp = ref_result(op, a, b);
            run_op(op, a, b, rd, lat, acc, sg, mw, mv);
            n_cmp++; if (out_data !== exp || out_rd !== rd) begin n_err++;
                $display("FAIL rand_%0d_data op=%0d got %h/%0d want %h/%0d", i, op, out_data, out_rd, exp, rd); end
            n_cmp++;
            if (eh ? (lat !== 1 || acc !== 0) : (acc !== 1 || mv !== 1'b1)) begin n_err++;
                $display("FAIL rand_%0d_path op=%0d got lat=%0d acc=%0d want hit=%0b", i, op, lat, acc, eh); end
            release_out($urandom_range(0, 3));
            if (!eh) ref_commit(op, a, b);
        end
        n_cmp++; if (hold_err !== 0) begin n_err++;
            $display("FAIL rand_hold got %0d want 0", hold_err); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_src1 = '0;
        in_src2 = '0;
        in_rd = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mulhu();
        test_cache_pair();
        test_mulw();
        test_flush();
        test_backpressure();
        test_reset_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d compares", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
